// File: rtl/pipe_rf_pkg.sv
// Shared widths, side-write target constants and the side-write select type
// for the pipelined register file with load scoreboard.
package pipe_rf_pkg;

   localparam int DATA_W_DEF    = 32;
   localparam int ADDR_W_DEF    = 5;
   localparam int LINK_ADDR_DEF = 31;
   localparam int EPC_ADDR_DEF  = 26;
   localparam int PC_INC_DEF    = 4;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      LINK = 2'd1,
      EPC  = 2'd2
   } side_sel_e;

endpackage

// File: rtl/pipe_rf_scoreboard.sv
// Busy-bit scoreboard for outstanding loads: set on load issue, cleared by main write, set wins.
// Busy reads are combinational, pending_cnt is registered; PIPE_RF_BYPASS_EN exposes same-cycle clears.
module pipe_rf_scoreboard
   import pipe_rf_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              set,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic              busy_a,
   output logic              busy_b,
   output logic [ADDR_W:0]   pending_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;
   logic [ADDR_W:0]  cnt_nxt;

   always_comb begin
      busy_nxt = busy;
      if (clr && clr_addr != '0)
         busy_nxt[clr_addr] = 1'b0;
      if (set && set_addr != '0)
         busy_nxt[set_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_comb begin
      cnt_nxt = '0;
      for (int i = 0; i < DEPTH; i++)
         cnt_nxt = cnt_nxt + (ADDR_W + 1)'(busy_nxt[i]);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         busy        <= '0;
         pending_cnt <= '0;
      end else begin
         busy        <= busy_nxt;
         pending_cnt <= cnt_nxt;
      end
   end

   always_comb begin
      busy_a = busy[rd_addr_a];
      busy_b = busy[rd_addr_b];
`ifdef PIPE_RF_BYPASS_EN
      // A clear landing this cycle is visible early unless a new load re-marks the entry.
      if (clr && clr_addr == rd_addr_a && !(set && set_addr == rd_addr_a))
         busy_a = 1'b0;
      if (clr && clr_addr == rd_addr_b && !(set && set_addr == rd_addr_b))
         busy_b = 1'b0;
`endif
   end

endmodule

// File: rtl/pipe_regfile_sb.sv
// Two-read register file with main write, link/EPC side write and load scoreboard; reads combinational.
// Optional macro PIPE_RF_BYPASS_EN forwards same-cycle writes to the read ports.
module pipe_regfile_sb
   import pipe_rf_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int LINK_ADDR = LINK_ADDR_DEF,
   parameter int EPC_ADDR  = EPC_ADDR_DEF,
   parameter int PC_INC    = PC_INC_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              rd_busy_a,
   output logic              rd_busy_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              link_en,
   input  logic              irq_en,
   input  logic [DATA_W-1:0] pc,
   input  logic              sb_set,
   input  logic [ADDR_W-1:0] sb_addr,
   output logic [ADDR_W:0]   pending_cnt
);

   localparam int                DEPTH  = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_ADDR);
   localparam logic [ADDR_W-1:0] EPC_A  = ADDR_W'(EPC_ADDR);
   localparam logic [DATA_W-2:0] INC    = (DATA_W - 1)'(PC_INC);

   logic [DATA_W-1:0] mem [DEPTH];
   side_sel_e         side_sel;
   logic [ADDR_W-1:0] side_addr;
   logic [DATA_W-1:0] side_val;
   logic              main_we;
   logic              side_we;
   logic [ADDR_W-1:0] ra [2];
   logic [DATA_W-1:0] rd [2];

   // Kernel-mode pc suppresses side writes; interrupt takes precedence over link.
   always_comb begin
      side_sel = NONE;
      if (!pc[DATA_W-1]) begin
         if (irq_en)
            side_sel = EPC;
         else if (link_en)
            side_sel = LINK;
      end
   end

   assign side_addr = (side_sel == EPC) ? EPC_A : LINK_A;
   // Increment only the low field so the kernel bit never absorbs a carry.
   assign side_val  = {pc[DATA_W-1], pc[DATA_W-2:0] + INC};
   assign main_we   = wr_en && (wr_addr != '0);
   assign side_we   = (side_sel != NONE) && (side_addr != '0)
                      && !(main_we && wr_addr == side_addr);

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (main_we)
            mem[wr_addr] <= wr_data;
         if (side_we)
            mem[side_addr] <= side_val;
      end
   end

   assign ra[0] = rd_addr_a;
   assign ra[1] = rd_addr_b;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd[p] = (ra[p] == '0) ? '0 : mem[ra[p]];
`ifdef PIPE_RF_BYPASS_EN
         if (ra[p] != '0) begin
            if (main_we && wr_addr == ra[p])
               rd[p] = wr_data;
            else if (side_we && side_addr == ra[p])
               rd[p] = side_val;
         end
`endif
      end
   end

   assign rd_data_a = rd[0];
   assign rd_data_b = rd[1];

   pipe_rf_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_sb (
      .clk         (clk),
      .reset       (reset),
      .set         (sb_set),
      .set_addr    (sb_addr),
      .clr         (main_we),
      .clr_addr    (wr_addr),
      .rd_addr_a   (rd_addr_a),
      .rd_addr_b   (rd_addr_b),
      .busy_a      (rd_busy_a),
      .busy_b      (rd_busy_b),
      .pending_cnt (pending_cnt)
   );

endmodule

// File: tb/tb_pipe_regfile_sb.sv
// Self-checking bench: directed scenarios plus random traffic against an array-based reference model.
module tb_pipe_regfile_sb;

   logic        clk;
   logic        reset;
   logic [4:0]  rd_addr_a, rd_addr_b;
   logic [31:0] rd_data_a, rd_data_b;
   logic        rd_busy_a, rd_busy_b;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        link_en, irq_en;
   logic [31:0] pc;
   logic        sb_set;
   logic [4:0]  sb_addr;
   logic [5:0]  pending_cnt;

   int errors = 0;
   int checks = 0;
   bit chk_on = 0;

   // Reference state: register contents and busy flags as plain arrays.
   logic [31:0] m_reg  [32];
   bit          m_busy [32];

   pipe_regfile_sb dut (
      .clk         (clk),
      .reset       (reset),
      .rd_addr_a   (rd_addr_a),
      .rd_addr_b   (rd_addr_b),
      .rd_data_a   (rd_data_a),
      .rd_data_b   (rd_data_b),
      .rd_busy_a   (rd_busy_a),
      .rd_busy_b   (rd_busy_b),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .link_en     (link_en),
      .irq_en      (irq_en),
      .pc          (pc),
      .sb_set      (sb_set),
      .sb_addr     (sb_addr),
      .pending_cnt (pending_cnt)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit side_on();
      return (irq_en || link_en) && !pc[31];
   endfunction

   function automatic int side_tgt();
      return irq_en ? 26 : 31;
   endfunction

   function automatic logic [31:0] side_value();
      return (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7FFF_FFFF);
   endfunction

   function automatic int model_cnt();
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      logic [31:0] v;
      if (a == 0) return 32'h0;
      v = m_reg[a];
`ifdef PIPE_RF_BYPASS_EN
      if (wr_en && wr_addr == a) v = wr_data;
      else if (side_on() && side_tgt() == int'(a)) v = side_value();
`endif
      return v;
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      logic b;
      b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef PIPE_RF_BYPASS_EN
      if (wr_en && wr_addr == a && !(sb_set && sb_addr == a)) b = 1'b0;
`endif
      return b;
   endfunction

   // Apply one clock edge's worth of architectural effect to the model.
   task automatic model_update();
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 0;
         end
      end else begin
         if (wr_en && wr_addr != 0) begin
            m_reg[wr_addr]  = wr_data;
            m_busy[wr_addr] = 0;
         end
         if (side_on() && !(wr_en && wr_addr != 0 && int'(wr_addr) == side_tgt()))
            m_reg[side_tgt()] = side_value();
         if (sb_set && sb_addr != 0)
            m_busy[sb_addr] = 1;
      end
   endtask

   task automatic clk_edge();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      wr_en = 0; wr_addr = 0; wr_data = 0;
      link_en = 0; irq_en = 0; pc = 0;
      sb_set = 0; sb_addr = 0;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("rd_data_a", rd_data_a, exp_rd(rd_addr_a));
         check("rd_data_b", rd_data_b, exp_rd(rd_addr_b));
         check("rd_busy_a", 32'(rd_busy_a), 32'(exp_busy(rd_addr_a)));
         check("rd_busy_b", 32'(rd_busy_b), 32'(exp_busy(rd_addr_b)));
         check("pending_cnt", 32'(pending_cnt), 32'(model_cnt()));
      end
   end

   initial begin
      reset = 0; rd_addr_a = 0; rd_addr_b = 0;
      idle();
      clk_edge();
      clk_edge();
      chk_on = 1;
      settle();
      check("reset_cnt", 32'(pending_cnt), 32'd0);
      reset = 1;

      // Main write and write to entry 0.
      wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
      clk_edge(); idle(); rd_addr_a = 5;
      settle(); check("wr5", rd_data_a, 32'hDEADBEEF);
      wr_en = 1; wr_addr = 0; wr_data = 32'h1; rd_addr_b = 0;
      clk_edge(); idle();
      settle(); check("wr0", rd_data_b, 32'h0);

      // Link, irq priority, kernel suppression.
      link_en = 1; pc = 32'h0040_0010;
      clk_edge(); idle(); rd_addr_a = 31;
      settle(); check("link", rd_data_a, 32'h0040_0014);
      wr_en = 1; wr_addr = 31; wr_data = 32'h1234_5678;
      clk_edge(); idle();
      irq_en = 1; link_en = 1; pc = 32'h0040_0010;
      clk_edge(); idle(); rd_addr_a = 26; rd_addr_b = 31;
      settle();
      check("irq_epc", rd_data_a, 32'h0040_0014);
      check("irq_link_kept", rd_data_b, 32'h1234_5678);
      link_en = 1; pc = 32'h8000_0010;
      clk_edge(); idle(); rd_addr_b = 31;
      settle(); check("kernel_supp", rd_data_b, 32'h1234_5678);

      // Low-field wrap leaves kernel bit clear.
      link_en = 1; pc = 32'h7FFF_FFFC;
      clk_edge(); idle(); rd_addr_a = 31;
      settle(); check("wrap", rd_data_a, 32'h0);

      // Main write beats side write to the same entry.
      irq_en = 1; pc = 32'h100; wr_en = 1; wr_addr = 26; wr_data = 32'hAA;
      clk_edge(); idle(); rd_addr_a = 26;
      settle(); check("main_wins", rd_data_a, 32'hAA);

      // Scoreboard set/clear.
      sb_set = 1; sb_addr = 8;
      clk_edge(); sb_addr = 9;
      clk_edge(); idle(); rd_addr_a = 8; rd_addr_b = 9;
      settle();
      check("cnt2", 32'(pending_cnt), 32'd2);
      check("busy8", 32'(rd_busy_a), 32'd1);
      wr_en = 1; wr_addr = 8; wr_data = 32'h8; sb_set = 1; sb_addr = 8;
      clk_edge(); idle();
      settle();
      check("set_wins", 32'(rd_busy_a), 32'd1);
      check("cnt_still2", 32'(pending_cnt), 32'd2);
      wr_en = 1; wr_addr = 9; wr_data = 32'h9;
      clk_edge(); idle();
      settle(); check("cnt1", 32'(pending_cnt), 32'd1);

      // Reset mid-operation.
      wr_en = 1; wr_addr = 3; wr_data = 32'h33;
      clk_edge(); wr_addr = 4; wr_data = 32'h44;
      clk_edge(); idle(); sb_set = 1; sb_addr = 7;
      clk_edge(); idle(); reset = 0; wr_en = 1; wr_addr = 3; wr_data = 32'h77; sb_set = 1; sb_addr = 5;
      clk_edge(); idle(); reset = 1; rd_addr_a = 3; rd_addr_b = 4;
      settle();
      check("rst_rd3", rd_data_a, 32'h0);
      check("rst_rd4", rd_data_b, 32'h0);
      check("rst_cnt", 32'(pending_cnt), 32'd0);
`ifdef PIPE_RF_BYPASS_EN
      wr_en = 1; wr_addr = 3; wr_data = 32'h55;
      settle(); check("bypass_rd3", rd_data_a, 32'h55);
      clk_edge(); idle();
`endif

      // Random traffic; the negedge compare process checks every cycle.
      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 63) != 0);
         wr_en     = ($urandom_range(0, 2) != 0);
         wr_addr   = 5'($urandom);
         wr_data   = $urandom;
         link_en   = ($urandom_range(0, 3) == 0);
         irq_en    = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 1) == 1)
            wr_addr = ($urandom_range(0, 1) == 1) ? 5'd26 : 5'd31;
         pc = $urandom;
         if ($urandom_range(0, 3) == 0)
            pc = {pc[31], 31'h7FFF_FFFC + 31'($urandom_range(0, 3))};
         sb_set    = ($urandom_range(0, 1) == 1);
         sb_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
         rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
         rd_addr_b = ($urandom_range(0, 2) == 0) ? 5'd26 : 5'($urandom);
         clk_edge();
      end
      idle();
      reset = 1;
      clk_edge();
      settle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
